// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V core:
// FSM state codes, opcodes and datapath select values.
package riscv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R)
            || (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode to immediate-format decode.
// Unknown opcodes fall back to the I format.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        unique case (1'b1)
            (op == OP_SW):  imm_src = IMM_S;
            (op == OP_BEQ): imm_src = IMM_B;
            (op == OP_JAL): imm_src = IMM_J;
            default:        imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback sequencing.
// Define MAIN_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes in a TRAP state.
module main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [1:0] ImmSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       InstrDone,
    output logic       Illegal
);

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t state;
    state_t state_n;

    logic ir_w;
    logic pc_upd;
    logic branch;
    logic reg_w;
    logic mem_w;
    logic done;
    logic ill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = S_FETCH;
        ALUOp     = ALUOP_ADD;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        ir_w      = 1'b0;
        pc_upd    = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        done      = 1'b0;
        ill       = 1'b0;
        case (state)
            S_FETCH: begin
                ir_w      = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_upd    = 1'b1;
                state_n   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                unique case (1'b1)
                    (op == OP_LW),
                    (op == OP_SW):  state_n = S_MEMADR;
                    (op == OP_R):   state_n = S_EXECUTER;
                    (op == OP_I):   state_n = S_EXECUTEI;
                    (op == OP_BEQ): state_n = S_BEQ;
                    (op == OP_JAL): state_n = S_JAL;
                    default: begin
                        // Without a trap, an unknown op retires as a NOP here.
                        state_n = TRAP_EN ? S_TRAP : S_FETCH;
                        done    = !TRAP_EN;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                unique case (1'b1)
                    (op == OP_LW): state_n = S_MEMREAD;
                    (op == OP_SW): state_n = S_MEMWRITE;
                    default:       state_n = S_FETCH;
                endcase
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                done      = 1'b1;
                state_n   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_w   = 1'b1;
                done    = 1'b1;
                state_n = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w   = 1'b1;
                done    = 1'b1;
                state_n = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_SUB;
                branch  = 1'b1;
                done    = 1'b1;
                state_n = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pc_upd  = 1'b1;
                state_n = S_ALUWB;
            end
            S_TRAP: begin
                ill     = TRAP_EN;
                state_n = (TRAP_EN && ILLEGAL_STICKY) ? S_TRAP : S_FETCH;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    imm_src_decoder u_imm (
        .op      (op),
        .imm_src (ImmSrc)
    );

    // Enables are masked by reset so FETCH does not write while held in reset.
    assign IRWrite   = !reset && ir_w;
    assign PCWrite   = !reset && (pc_upd || (branch && Zero));
    assign RegWrite  = !reset && reg_w;
    assign MemWrite  = !reset && mem_w;
    assign InstrDone = !reset && done;
    assign Illegal   = !reset && ill;

endmodule

// File: tb/tb_main_fsm.sv
// Directed table-driven bench for main_fsm plus a few
// hand-written multi-cycle sequences (reset abort, in-cycle Zero).
module tb_main_fsm;
    import riscv_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       Zero;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       AdrSrc;
    logic [1:0] ImmSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       InstrDone;
    logic       Illegal;

    int n_run;
    int n_fail;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .Zero      (Zero),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .AdrSrc    (AdrSrc),
        .ImmSrc    (ImmSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .InstrDone (InstrDone),
        .Illegal   (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc}
    localparam logic [8:0] C_FETCH = 9'b00_00_10_10_0;
    localparam logic [8:0] C_DEC   = 9'b00_01_01_00_0;
    localparam logic [8:0] C_MA    = 9'b00_10_01_00_0;
    localparam logic [8:0] C_MR    = 9'b00_00_00_00_1;
    localparam logic [8:0] C_MWB   = 9'b00_00_00_01_0;
    localparam logic [8:0] C_MW    = 9'b00_00_00_00_1;
    localparam logic [8:0] C_ER    = 9'b10_10_00_00_0;
    localparam logic [8:0] C_EI    = 9'b10_10_01_00_0;
    localparam logic [8:0] C_AWB   = 9'b00_00_00_00_0;
    localparam logic [8:0] C_BEQ   = 9'b01_10_00_00_0;
    localparam logic [8:0] C_JAL   = 9'b00_01_10_00_0;
    localparam logic [8:0] C_TRAP  = 9'b00_00_00_00_0;

    // en = {IRWrite, PCWrite, RegWrite, MemWrite, InstrDone, Illegal}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_FETCH = 6'b110000;
    localparam logic [5:0] E_WB    = 6'b001010;
    localparam logic [5:0] E_MW    = 6'b000110;
    localparam logic [5:0] E_BEQ1  = 6'b010010;
    localparam logic [5:0] E_DONE  = 6'b000010;
    localparam logic [5:0] E_JAL   = 6'b010000;
    localparam logic [5:0] E_ILL   = 6'b000001;

    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       z;
        logic [8:0] ctl;
        logic [5:0] en;
        logic [1:0] imm;
        string      name;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rst, input logic [6:0] o,
                                input logic z, input logic [8:0] c,
                                input logic [5:0] e, input logic [1:0] im,
                                input string nm);
        vec_t v;
        v.rst = rst; v.op = o; v.z = z;
        v.ctl = c; v.en = e; v.imm = im; v.name = nm;
        vq.push_back(v);
    endfunction

    function automatic logic [16:0] snap();
        return {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                IRWrite, PCWrite, RegWrite, MemWrite, InstrDone, Illegal,
                ImmSrc};
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [16:0] got, input logic [16:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d] got=%b expected=%b", nm, idx, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] o, input logic z);
        @(negedge clk);
        reset = r; op = o; Zero = z;
        #1;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        reset  = 1'b1;
        op     = OP_LW;
        Zero   = 1'b0;

        add(1, OP_LW, 0, C_FETCH, E_NONE, IMM_I, "reset");
        add(0, OP_LW, 0, C_FETCH, E_FETCH, IMM_I, "lw_fetch");
        add(0, OP_LW, 0, C_DEC, E_NONE, IMM_I, "lw_decode");
        add(0, OP_LW, 0, C_MA, E_NONE, IMM_I, "lw_memadr");
        add(0, OP_LW, 0, C_MR, E_NONE, IMM_I, "lw_memread");
        add(0, OP_LW, 0, C_MWB, E_WB, IMM_I, "lw_memwb");
        add(0, OP_R, 0, C_FETCH, E_FETCH, IMM_I, "r_fetch");
        add(0, OP_R, 0, C_DEC, E_NONE, IMM_I, "r_decode");
        add(0, OP_R, 0, C_ER, E_NONE, IMM_I, "r_exec");
        add(0, OP_R, 0, C_AWB, E_WB, IMM_I, "r_aluwb");
        add(0, OP_I, 0, C_FETCH, E_FETCH, IMM_I, "i_fetch");
        add(0, OP_I, 0, C_DEC, E_NONE, IMM_I, "i_decode");
        add(0, OP_I, 0, C_EI, E_NONE, IMM_I, "i_exec");
        add(0, OP_I, 0, C_AWB, E_WB, IMM_I, "i_aluwb");
        add(0, OP_BEQ, 1, C_FETCH, E_FETCH, IMM_B, "beq1_fetch");
        add(0, OP_BEQ, 1, C_DEC, E_NONE, IMM_B, "beq1_decode");
        add(0, OP_BEQ, 1, C_BEQ, E_BEQ1, IMM_B, "beq1_taken");
        add(0, OP_BEQ, 0, C_FETCH, E_FETCH, IMM_B, "beq0_fetch");
        add(0, OP_BEQ, 0, C_DEC, E_NONE, IMM_B, "beq0_decode");
        add(0, OP_BEQ, 0, C_BEQ, E_DONE, IMM_B, "beq0_not_taken");
        add(0, OP_SW, 0, C_FETCH, E_FETCH, IMM_S, "sw_fetch");
        add(0, OP_SW, 0, C_DEC, E_NONE, IMM_S, "sw_decode");
        add(0, OP_SW, 0, C_MA, E_NONE, IMM_S, "sw_memadr");
        add(0, OP_SW, 0, C_MW, E_MW, IMM_S, "sw_memwrite");
        add(0, OP_JAL, 0, C_FETCH, E_FETCH, IMM_J, "jal_fetch");
        add(0, OP_JAL, 0, C_DEC, E_NONE, IMM_J, "jal_decode");
        add(0, OP_JAL, 0, C_JAL, E_JAL, IMM_J, "jal_jal");
        add(0, OP_JAL, 0, C_AWB, E_WB, IMM_J, "jal_aluwb");
        add(0, OP_LW, 0, C_FETCH, E_FETCH, IMM_I, "abort_fetch");
        add(0, OP_LW, 0, C_DEC, E_NONE, IMM_I, "abort_decode");
        add(0, OP_LW, 0, C_MA, E_NONE, IMM_I, "abort_memadr");
        add(1, OP_LW, 0, C_FETCH, E_NONE, IMM_I, "abort_reset");
        add(0, OP_R, 0, C_FETCH, E_FETCH, IMM_I, "post_fetch");
        add(0, OP_R, 0, C_DEC, E_NONE, IMM_I, "post_decode");
        add(0, OP_R, 0, C_ER, E_NONE, IMM_I, "post_exec");
        add(0, OP_R, 0, C_AWB, E_WB, IMM_I, "post_aluwb");
        add(0, OP_BAD, 0, C_FETCH, E_FETCH, IMM_I, "bad_fetch");
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        add(0, OP_BAD, 0, C_DEC, E_NONE, IMM_I, "bad_decode");
        add(0, OP_BAD, 0, C_TRAP, E_ILL, IMM_I, "bad_trap");
        add(0, OP_BAD, 0, C_TRAP, E_ILL, IMM_I, "bad_trap_hold");
        add(0, OP_LW, 0, C_TRAP, E_ILL, IMM_I, "bad_trap_hold2");
`else
        add(0, OP_BAD, 0, C_DEC, E_DONE, IMM_I, "bad_decode_nop");
        add(0, OP_BAD, 0, C_FETCH, E_FETCH, IMM_I, "bad_refetch");
`endif
        add(1, OP_LW, 0, C_FETCH, E_NONE, IMM_I, "reset2");
        add(0, OP_LW, 0, C_FETCH, E_FETCH, IMM_I, "reset2_fetch");

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].op, vq[i].z);
            chk(vq[i].name, i, snap(),
                {vq[i].ctl, vq[i].en, vq[i].imm});
        end

        // Zero toggled inside the BEQ cycle reaches PCWrite immediately.
        step(1, OP_BEQ, 0);
        step(0, OP_BEQ, 1);
        chk("zq_fetch_pc", 0, {16'd0, PCWrite}, 17'd1);
        step(0, OP_BEQ, 1);
        chk("zq_decode_pc", 0, {16'd0, PCWrite}, 17'd0);
        step(0, OP_BEQ, 0);
        chk("zq_beq_z0", 0, {16'd0, PCWrite}, 17'd0);
        Zero = 1'b1;
        #1;
        chk("zq_beq_z1", 0, {16'd0, PCWrite}, 17'd1);
        Zero = 1'b0;
        #1;
        chk("zq_beq_z0b", 0, {16'd0, PCWrite}, 17'd0);

        // Reset asserted mid-MEMREAD: no writeback before or after.
        step(0, OP_LW, 0);
        step(0, OP_LW, 0);
        step(0, OP_LW, 0);
        step(0, OP_LW, 0);
        chk("ab_memread", 0, snap(), {C_MR, E_NONE, IMM_I});
        #2;
        reset = 1'b1;
        #1;
        chk("ab_in_reset", 0, snap(), {C_FETCH, E_NONE, IMM_I});
        step(1, OP_LW, 0);
        chk("ab_held_regw", 0, {16'd0, RegWrite}, 17'd0);
        step(0, OP_LW, 0);
        chk("ab_restart", 0, snap(), {C_FETCH, E_FETCH, IMM_I});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
